threat_arbiter: RTL

Scheduler that shares a single threat-evaluation engine (the block that scans a 15x15 gobang board and returns attack/defend candidate coordinates, candidate count and win flag) between two requesters: the win-checker (requester 0) and the AI move search (requester 1). It arbitrates round-robin, latches the granted board and turn, and sequences the engine's start/finish handshake. It returns the engine result on a single tagged response bus. It sits between the game controller's requesters and the engine instance.

---
 rtl/threat_arbiter_if.sv | 73 +++++++
 rtl/threat_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/threat_arbiter_if.sv
// -----------------------------------------------------------------------------
// threat_arbiter_if
//
// Groups every request, engine and response signal of threat_arbiter into one
// bundle. Signal names keep their i_/o_ prefixes as seen from the arbiter, so
// the arbiter's view is the 'slave' modport and the environment (requesters,
// engine, response consumer) drives the bus through the 'master' modport.
//
// Parameters:
//   BOARD_W  board snapshot width (225 cells x 2 bits)
//
// Signals:
//   i_req0_*/i_req1_*  request valid, turn and board from requesters 0 and 1
//   o_req0/1_grant     one-cycle grant pulses
//   o_eng_*            start pulse, latched turn/board and abort pulse to engine
//   i_eng_*            finish pulse and result fields from the engine
//   o_rsp_*            tagged, registered response bus
//   o_busy             arbiter is not idle
// -----------------------------------------------------------------------------
interface threat_arbiter_if #(
    parameter int BOARD_W = 450
);
    // Requesters
    logic               i_req0_valid;
    logic               i_req1_valid;
    logic               i_req0_turn;
    logic               i_req1_turn;
    logic [BOARD_W-1:0] i_req0_board;
    logic [BOARD_W-1:0] i_req1_board;
    logic               o_req0_grant;
    logic               o_req1_grant;

    // Engine
    logic               o_eng_start;
    logic               o_eng_turn;
    logic [BOARD_W-1:0] o_eng_board;
    logic               o_eng_abort;
    logic               i_eng_finish;
    logic [49:0]        i_eng_posX;
    logic [49:0]        i_eng_posY;
    logic [5:0]         i_eng_size;
    logic [1:0]         i_eng_win;

    // Response
    logic               o_rsp_valid;
    logic               o_rsp_id;
    logic [49:0]        o_rsp_posX;
    logic [49:0]        o_rsp_posY;
    logic [5:0]         o_rsp_size;
    logic [1:0]         o_rsp_win;
    logic               o_rsp_timeout;
    logic               o_busy;

    modport slave (
        input  i_req0_valid, i_req1_valid, i_req0_turn, i_req1_turn,
        input  i_req0_board, i_req1_board,
        output o_req0_grant, o_req1_grant,
        output o_eng_start, o_eng_turn, o_eng_board, o_eng_abort,
        input  i_eng_finish, i_eng_posX, i_eng_posY, i_eng_size, i_eng_win,
        output o_rsp_valid, o_rsp_id, o_rsp_posX, o_rsp_posY, o_rsp_size,
        output o_rsp_win, o_rsp_timeout, o_busy
    );

    modport master (
        output i_req0_valid, i_req1_valid, i_req0_turn, i_req1_turn,
        output i_req0_board, i_req1_board,
        input  o_req0_grant, o_req1_grant,
        input  o_eng_start, o_eng_turn, o_eng_board, o_eng_abort,
        output i_eng_finish, i_eng_posX, i_eng_posY, i_eng_size, i_eng_win,
        input  o_rsp_valid, o_rsp_id, o_rsp_posX, o_rsp_posY, o_rsp_size,
        input  o_rsp_win, o_rsp_timeout, o_busy
    );
endinterface

// File: rtl/threat_arbiter.sv
// -----------------------------------------------------------------------------
// threat_arbiter
//
// Shares one threat-evaluation engine between the win-checker (requester 0)
// and the AI move search (requester 1). Requests are arbitrated round-robin,
// the winner's board and turn are latched for the engine, the engine's
// start/finish handshake is sequenced, and the result is returned on a single
// response bus tagged with the owning requester id.
//
// Sequence: IDLE -> START (grant + start pulse) -> WAIT (until finish)
//           -> RESP (response pulse) -> IDLE.
//
// Ports:
//   i_clk    clock, all logic on the rising edge
//   i_rst_n  synchronous active-low reset
//   bus      threat_arbiter_if.slave: requests, engine handshake, response
//
// Parameters:
//   BOARD_W  board width (450)
//   TO_W     timeout counter width      (only with THREAT_ARB_TIMEOUT_EN)
//   TIMEOUT  WAIT cycles before abort   (only with THREAT_ARB_TIMEOUT_EN)
//
// Optional feature macro: THREAT_ARB_TIMEOUT_EN
//   Defined   : a WAIT-cycle counter aborts a stuck engine and returns an
//               all-zero response flagged with o_rsp_timeout.
//   Undefined : WAIT lasts until finish; o_eng_abort and o_rsp_timeout are 0.
// -----------------------------------------------------------------------------
module threat_arbiter #(
    parameter int BOARD_W = 450
`ifdef THREAT_ARB_TIMEOUT_EN
    ,
    parameter int TO_W    = 12,
    parameter int TIMEOUT = 4095
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    threat_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e             state_q, state_d;
    logic               id_q, id_d;          // owner of the in-flight request
    logic               last_q, last_d;      // requester granted most recently
    logic               turn_q, turn_d;
    logic [BOARD_W-1:0] board_q, board_d;
    logic [49:0]        rsp_posx_q, rsp_posx_d;
    logic [49:0]        rsp_posy_q, rsp_posy_d;
    logic [5:0]         rsp_size_q, rsp_size_d;
    logic [1:0]         rsp_win_q, rsp_win_d;
    logic               win_id;
    logic               any_req;

`ifdef THREAT_ARB_TIMEOUT_EN
    logic [TO_W-1:0]    cnt_q, cnt_d;
    logic               rsp_to_q, rsp_to_d;
    logic               abort_c;
`endif

    // Round-robin pick: a lone request always wins; on a tie the requester
    // that was not granted last wins.
    assign any_req = bus.i_req0_valid | bus.i_req1_valid;
    assign win_id  = bus.i_req1_valid & (~bus.i_req0_valid | ~last_q);

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first so that no
        // path through the case statement leaves it unassigned (no latches).
        state_d    = state_q;
        id_d       = id_q;
        last_d     = last_q;
        turn_d     = turn_q;
        board_d    = board_q;
        rsp_posx_d = rsp_posx_q;
        rsp_posy_d = rsp_posy_q;
        rsp_size_d = rsp_size_q;
        rsp_win_d  = rsp_win_q;
`ifdef THREAT_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        rsp_to_d   = rsp_to_q;
        abort_c    = 1'b0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    id_d    = win_id;
                    last_d  = win_id;
                    turn_d  = win_id ? bus.i_req1_turn  : bus.i_req0_turn;
                    board_d = win_id ? bus.i_req1_board : bus.i_req0_board;
                    state_d = ST_START;
                end
            end

            ST_START: begin
`ifdef THREAT_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                // Finish takes priority over a timeout landing in the same cycle.
                if (bus.i_eng_finish) begin
                    rsp_posx_d = bus.i_eng_posX;
                    rsp_posy_d = bus.i_eng_posY;
                    rsp_size_d = bus.i_eng_size;
                    rsp_win_d  = bus.i_eng_win;
`ifdef THREAT_ARB_TIMEOUT_EN
                    rsp_to_d   = 1'b0;
`endif
                    state_d    = ST_RESP;
                end
`ifdef THREAT_ARB_TIMEOUT_EN
                else if (cnt_q == TO_W'(TIMEOUT)) begin
                    abort_c    = 1'b1;
                    rsp_posx_d = '0;
                    rsp_posy_d = '0;
                    rsp_size_d = '0;
                    rsp_win_d  = '0;
                    rsp_to_d   = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
`endif
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers
        // update together from the values sampled at the same clock edge.
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            id_q       <= 1'b0;
            last_q     <= 1'b1;   // requester 0 wins the first tie
            turn_q     <= 1'b0;
            board_q    <= '0;
            rsp_posx_q <= '0;
            rsp_posy_q <= '0;
            rsp_size_q <= '0;
            rsp_win_q  <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            last_q     <= last_d;
            turn_q     <= turn_d;
            board_q    <= board_d;
            rsp_posx_q <= rsp_posx_d;
            rsp_posy_q <= rsp_posy_d;
            rsp_size_q <= rsp_size_d;
            rsp_win_q  <= rsp_win_d;
        end
    end

`ifdef THREAT_ARB_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q    <= '0;
            rsp_to_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rsp_to_q <= rsp_to_d;
        end
    end

    assign bus.o_eng_abort   = abort_c;
    assign bus.o_rsp_timeout = rsp_to_q;
`else
    assign bus.o_eng_abort   = 1'b0;
    assign bus.o_rsp_timeout = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Outputs: pulses are decoded from the registered state, so reset forces
    // them all to 0 together with the state.
    // -------------------------------------------------------------------------
    assign bus.o_req0_grant = (state_q == ST_START) & ~id_q;
    assign bus.o_req1_grant = (state_q == ST_START) &  id_q;
    assign bus.o_eng_start  = (state_q == ST_START);
    assign bus.o_eng_turn   = turn_q;
    assign bus.o_eng_board  = board_q;
    assign bus.o_rsp_valid  = (state_q == ST_RESP);
    assign bus.o_rsp_id     = id_q;
    assign bus.o_rsp_posX   = rsp_posx_q;
    assign bus.o_rsp_posY   = rsp_posy_q;
    assign bus.o_rsp_size   = rsp_size_q;
    assign bus.o_rsp_win    = rsp_win_q;
    assign bus.o_busy       = (state_q != ST_IDLE);

endmodule
